// File: rtl/tx_sample_sched.sv
// Transmit sample scheduler: releases one FIFO sample per programmable period to the
// serializer over valid/ready, substituting a fill sample when the FIFO runs dry.
module tx_sample_sched #(
    parameter int DATA_W    = 16,
    parameter int DIV_W     = 16,
    parameter int CNT_W     = 16,
    parameter bit HOLD_LAST = 1'b0
) (
    input  logic              mclk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [DIV_W-1:0]  period,
    input  logic              fifo_rempty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rinc,
    output logic              smp_valid,
    output logic [DATA_W-1:0] smp_data,
    input  logic              smp_ready,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  slip_cnt,
    input  logic              cnt_clr,
    output logic              running
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PRESENT
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              smp_valid_q, smp_valid_d;
    logic [DATA_W-1:0] smp_data_q, smp_data_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]  underrun_q, underrun_d;
    logic [CNT_W-1:0]  slip_q, slip_d;
    logic              tick;
    logic              pop;
    logic              underrun_ev;
    logic              slip_ev;

    // Comparing with >= lets a shrinking period take effect without a wraparound.
    assign tick = enable && (div_q >= period);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        smp_valid_d = smp_valid_q;
        smp_data_d  = smp_data_q;
        last_d      = last_q;
        underrun_d  = underrun_q;
        slip_d      = slip_q;
        pop         = 1'b0;
        underrun_ev = 1'b0;
        slip_ev     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d       = '0;
                smp_valid_d = 1'b0;
                if (enable) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    smp_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                    if (!fifo_rempty) begin
                        pop        = 1'b1;
                        smp_data_d = fifo_rdata;
                        last_d     = fifo_rdata;
                    end else begin
                        smp_data_d  = HOLD_LAST ? last_q : '0;
                        underrun_ev = 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                // The divider keeps running so a stalled serializer does not shift the cadence.
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (smp_valid_q && smp_ready) begin
                    smp_valid_d = 1'b0;
                    state_d     = ST_WAIT;
                end else if (tick) begin
                    slip_ev = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                div_d       = '0;
                smp_valid_d = 1'b0;
            end
        endcase

        if (!enable) begin
            state_d     = ST_IDLE;
            div_d       = '0;
            smp_valid_d = 1'b0;
        end

        // A clear coincident with an event leaves the count at one, not zero.
        if (cnt_clr) begin
            underrun_d = CNT_W'(underrun_ev);
        end else if (underrun_ev && (underrun_q != '1)) begin
            underrun_d = underrun_q + CNT_W'(1);
        end

        if (cnt_clr) begin
            slip_d = CNT_W'(slip_ev);
        end else if (slip_ev && (slip_q != '1)) begin
            slip_d = slip_q + CNT_W'(1);
        end
    end

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            smp_valid_q <= 1'b0;
            smp_data_q  <= '0;
            last_q      <= '0;
            underrun_q  <= '0;
            slip_q      <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            smp_valid_q <= smp_valid_d;
            smp_data_q  <= smp_data_d;
            last_q      <= last_d;
            underrun_q  <= underrun_d;
            slip_q      <= slip_d;
        end
    end

    assign fifo_rinc    = pop & resetn;
    assign smp_valid    = smp_valid_q;
    assign smp_data     = smp_data_q;
    assign underrun_cnt = underrun_q;
    assign slip_cnt     = slip_q;
    assign running      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_sample_sched.sv
// Bench for tx_sample_sched: two instances (zero-fill with 4-bit counters, hold-last with
// 16-bit counters) against a tick-sequence reference model and directed expectations.
module tb_tx_sample_sched;

    localparam int MAXC = 128;

    logic        mclk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        cnt_clr;
    logic        smp_ready;
    logic        fifo_rempty;
    logic [15:0] fifo_rdata;
    logic [15:0] period;

    logic        rinc_a, valid_a, running_a;
    logic [15:0] data_a;
    logic [3:0]  under_a, slip_a;
    logic        rinc_b, valid_b, running_b;
    logic [15:0] data_b;
    logic [15:0] under_b, slip_b;

    always #5 mclk = ~mclk;

    tx_sample_sched #(.DATA_W(16), .DIV_W(16), .CNT_W(4), .HOLD_LAST(1'b0)) dut_a (
        .mclk(mclk), .resetn(resetn), .enable(enable), .period(period),
        .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata), .fifo_rinc(rinc_a),
        .smp_valid(valid_a), .smp_data(data_a), .smp_ready(smp_ready),
        .underrun_cnt(under_a), .slip_cnt(slip_a), .cnt_clr(cnt_clr), .running(running_a)
    );

    tx_sample_sched #(.DATA_W(16), .DIV_W(16), .CNT_W(16), .HOLD_LAST(1'b1)) dut_b (
        .mclk(mclk), .resetn(resetn), .enable(enable), .period(period),
        .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata), .fifo_rinc(rinc_b),
        .smp_valid(valid_b), .smp_data(data_b), .smp_ready(smp_ready),
        .underrun_cnt(under_b), .slip_cnt(slip_b), .cnt_clr(cnt_clr), .running(running_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fq[$];
    logic        rp[MAXC];
    logic        r_va[MAXC], r_vb[MAXC], r_ra[MAXC], r_rb[MAXC];
    logic [15:0] r_da[MAXC], r_db[MAXC];
    logic        e_v[MAXC], e_r[MAXC];
    logic [15:0] e_d0[MAXC], e_d1[MAXC];
    int          exp_under, exp_slip;
    logic [15:0] model_last;
    logic        pend_pop;

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic do_reset();
        resetn      = 1'b0;
        enable      = 1'b0;
        cnt_clr     = 1'b0;
        smp_ready   = 1'b0;
        period      = 16'd0;
        fifo_rempty = 1'b1;
        fifo_rdata  = 16'd0;
        pend_pop    = 1'b0;
        fq.delete();
        exp_under   = 0;
        exp_slip    = 0;
        model_last  = 16'd0;
        repeat (2) @(posedge mclk);
        #3 resetn = 1'b1;
    endtask

    // Reference: ticks land at p+1, 2p+2, ... after enable; a tick while no sample is
    // outstanding issues one, a tick before the handshake is a slip, a tick on it is dropped.
    task automatic build_model(input int n, input int p);
        logic [15:0] mq[$];
        logic [15:0] d0, d1;
        int t, s, hs;
        mq = fq;
        for (int c = 0; c < MAXC; c++) begin
            e_v[c] = 1'b0; e_r[c] = 1'b0; e_d0[c] = 16'd0; e_d1[c] = 16'd0;
        end
        hs = -1;
        t  = p + 1;
        while (t < n) begin
            if (t > hs) begin
                if (mq.size() > 0) begin
                    d0 = mq.pop_front();
                    d1 = d0;
                    model_last = d0;
                    e_r[t] = 1'b1;
                end else begin
                    d0 = 16'd0;
                    d1 = model_last;
                    if (t <= n - 2) exp_under++;
                end
                s  = t + 1;
                hs = s;
                while (hs < n && rp[hs] !== 1'b1) hs++;
                for (int c = s; c <= hs && c < n; c++) begin
                    e_v[c] = 1'b1; e_d0[c] = d0; e_d1[c] = d1;
                end
            end else if (t < hs) begin
                if (t <= n - 2) exp_slip++;
            end
            t += p + 1;
        end
    endtask

    // Enable goes high in cycle 0; the TB FIFO pops on the edge after a sampled fifo_rinc.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge mclk);
            #1;
            if (pend_pop && fq.size() > 0) void'(fq.pop_front());
            enable      = 1'b1;
            fifo_rempty = (fq.size() == 0);
            fifo_rdata  = fifo_rempty ? 16'($urandom) : fq[0];
            smp_ready   = rp[c];
            #1;
            r_va[c] = valid_a; r_vb[c] = valid_b;
            r_ra[c] = rinc_a;  r_rb[c] = rinc_b;
            r_da[c] = data_a;  r_db[c] = data_b;
            pend_pop = rinc_a;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1; enable = 1'b0; cnt_clr = 1'b0; smp_ready = 1'b0;
        period = 16'd2; fifo_rempty = 1'b1; fifo_rdata = 16'd0;
        #1;
        resetn = 1'b0; enable = 1'b1; fifo_rempty = 1'b0; fifo_rdata = 16'h1234; smp_ready = 1'b1;
        #2;
        checks++;
        if ({valid_a, valid_b, rinc_a, rinc_b, running_a, running_b} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctl got %b%b%b%b%b%b expected 000000", valid_a, valid_b, rinc_a, rinc_b, running_a, running_b);
        end
        checks++;
        if (data_a !== 16'd0 || data_b !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h/%h expected 0000/0000", data_a, data_b);
        end
        checks++;
        if (under_a !== 4'd0 || slip_a !== 4'd0 || under_b !== 16'd0 || slip_b !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt got %0d %0d %0d %0d expected all 0", under_a, slip_a, under_b, slip_b);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge mclk);
            #2;
            checks++;
            if ({rinc_a, rinc_b, running_a, valid_a} !== 4'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d rinc/running/valid got %b%b%b%b expected 0000", k, rinc_a, rinc_b, running_a, valid_a);
            end
        end
    endtask

    task automatic test_basic_cadence();
        int pops;
        do_reset();
        period = 16'd3;
        fq = {16'h1111, 16'h2222, 16'h3333};
        for (int c = 0; c < MAXC; c++) rp[c] = 1'b1;
        build_model(22, 3);
        run_cycles(22);
        for (int c = 0; c < 22; c++) begin
            checks++;
            if ({r_va[c], r_vb[c], r_ra[c], r_rb[c]} !== {e_v[c], e_v[c], e_r[c], e_r[c]}) begin
                errors++;
                $display("[TB] FAIL basic_ctl cycle %0d valid/rinc got %b%b%b%b expected %b%b%b%b", c, r_va[c], r_vb[c], r_ra[c], r_rb[c], e_v[c], e_v[c], e_r[c], e_r[c]);
            end
            if (e_v[c]) begin
                checks++;
                if (r_da[c] !== e_d0[c] || r_db[c] !== e_d1[c]) begin
                    errors++;
                    $display("[TB] FAIL basic_data cycle %0d got %h/%h expected %h/%h", c, r_da[c], r_db[c], e_d0[c], e_d1[c]);
                end
            end
        end
        checks++;
        if (r_va[4] !== 1'b0 || r_va[5] !== 1'b1 || r_da[5] !== 16'h1111 || r_da[9] !== 16'h2222 || r_da[13] !== 16'h3333) begin
            errors++;
            $display("[TB] FAIL basic_seq got v4=%b v5=%b %h %h %h expected 0 1 1111 2222 3333", r_va[4], r_va[5], r_da[5], r_da[9], r_da[13]);
        end
        checks++;
        if (r_da[17] !== 16'h0000 || r_da[21] !== 16'h0000 || r_db[17] !== 16'h3333 || r_db[21] !== 16'h3333) begin
            errors++;
            $display("[TB] FAIL basic_fill got a=%h,%h b=%h,%h expected a=0000,0000 b=3333,3333", r_da[17], r_da[21], r_db[17], r_db[21]);
        end
        pops = 0;
        for (int c = 0; c < 22; c++) pops += int'(r_ra[c]);
        checks++;
        if (pops != 3 || under_a !== 4'd2 || under_b !== 16'd2) begin
            errors++;
            $display("[TB] FAIL basic_counts got pops=%0d under=%0d/%0d expected 3 2/2", pops, under_a, under_b);
        end
        checks++;
        if (under_b !== 16'(exp_under) || slip_b !== 16'(exp_slip) || under_a !== 4'(sat4(exp_under)) || slip_a !== 4'(sat4(exp_slip))) begin
            errors++;
            $display("[TB] FAIL basic_cnt got %0d %0d %0d %0d expected under=%0d slip=%0d", under_a, slip_a, under_b, slip_b, exp_under, exp_slip);
        end
    endtask

    task automatic test_backpressure();
        int  pops;
        logic stable;
        do_reset();
        period = 16'd1;
        fq = {16'hABCD};
        for (int c = 0; c < MAXC; c++) rp[c] = (c >= 3 && c <= 8) ? 1'b0 : 1'b1;
        build_model(10, 1);
        run_cycles(10);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({r_va[c], r_vb[c], r_ra[c], r_rb[c]} !== {e_v[c], e_v[c], e_r[c], e_r[c]}) begin
                errors++;
                $display("[TB] FAIL bp_ctl cycle %0d valid/rinc got %b%b%b%b expected %b%b%b%b", c, r_va[c], r_vb[c], r_ra[c], r_rb[c], e_v[c], e_v[c], e_r[c], e_r[c]);
            end
            if (e_v[c]) begin
                checks++;
                if (r_da[c] !== e_d0[c] || r_db[c] !== e_d1[c]) begin
                    errors++;
                    $display("[TB] FAIL bp_data cycle %0d got %h/%h expected %h/%h", c, r_da[c], r_db[c], e_d0[c], e_d1[c]);
                end
            end
        end
        stable = 1'b1;
        pops = 0;
        for (int c = 3; c <= 9; c++) if (r_va[c] !== 1'b1 || r_da[c] !== 16'hABCD) stable = 1'b0;
        for (int c = 0; c < 10; c++) pops += int'(r_ra[c]);
        checks++;
        if (stable !== 1'b1 || pops != 1 || slip_a !== 4'd3 || slip_b !== 16'd3) begin
            errors++;
            $display("[TB] FAIL bp_hold got stable=%b pops=%0d slip=%0d/%0d expected 1 1 3/3", stable, pops, slip_a, slip_b);
        end
        checks++;
        if (under_b !== 16'(exp_under) || slip_b !== 16'(exp_slip)) begin
            errors++;
            $display("[TB] FAIL bp_cnt got under=%0d slip=%0d expected %0d %0d", under_b, slip_b, exp_under, exp_slip);
        end
    endtask

    task automatic test_zero_period();
        int pops;
        do_reset();
        period = 16'd0;
        fq = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        for (int c = 0; c < MAXC; c++) rp[c] = 1'b1;
        build_model(17, 0);
        run_cycles(17);
        for (int c = 0; c < 17; c++) begin
            checks++;
            if ({r_va[c], r_vb[c], r_ra[c], r_rb[c]} !== {e_v[c], e_v[c], e_r[c], e_r[c]}) begin
                errors++;
                $display("[TB] FAIL zp_ctl cycle %0d valid/rinc got %b%b%b%b expected %b%b%b%b", c, r_va[c], r_vb[c], r_ra[c], r_rb[c], e_v[c], e_v[c], e_r[c], e_r[c]);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (r_va[2*k] !== 1'b1 || r_da[2*k] !== 16'(k) || r_db[2*k] !== 16'(k)) begin
                errors++;
                $display("[TB] FAIL zp_data sample %0d got v=%b %h/%h expected 1 %h", k, r_va[2*k], r_da[2*k], r_db[2*k], 16'(k));
            end
        end
        pops = 0;
        for (int c = 0; c < 17; c++) pops += int'(r_ra[c]);
        checks++;
        if (pops != 8 || under_a !== 4'd0 || under_b !== 16'd0) begin
            errors++;
            $display("[TB] FAIL zp_counts got pops=%0d under=%0d/%0d expected 8 0/0", pops, under_a, under_b);
        end
    endtask

    task automatic test_disable_mid_present();
        do_reset();
        period = 16'd2;
        fq = {16'h5A5A};
        for (int c = 0; c < MAXC; c++) rp[c] = 1'b0;
        build_model(8, 2);
        run_cycles(8);
        checks++;
        if (r_va[3] !== 1'b0 || r_va[4] !== 1'b1 || valid_a !== 1'b1 || data_a !== 16'h5A5A) begin
            errors++;
            $display("[TB] FAIL dis_pre got v3=%b v4=%b v=%b d=%h expected 0 1 1 5a5a", r_va[3], r_va[4], valid_a, data_a);
        end
        @(posedge mclk);
        #1 enable = 1'b0;
        #1;
        checks++;
        if (valid_a !== 1'b1 || rinc_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dis_same_cycle got valid=%b rinc=%b expected 1 0", valid_a, rinc_a);
        end
        @(posedge mclk);
        #2;
        checks++;
        if ({valid_a, valid_b, running_a, running_b, rinc_a} !== 5'b0 || fq.size() != 0) begin
            errors++;
            $display("[TB] FAIL dis_next got valid=%b%b running=%b%b rinc=%b fifo=%0d expected 00 00 0 0", valid_a, valid_b, running_a, running_b, rinc_a, fq.size());
        end
        for (int c = 0; c < MAXC; c++) rp[c] = 1'b1;
        build_model(12, 2);
        run_cycles(12);
        checks++;
        if (r_va[3] !== 1'b0 || r_va[4] !== 1'b1 || r_da[4] !== 16'h0000 || r_db[4] !== 16'h5A5A) begin
            errors++;
            $display("[TB] FAIL dis_reenable got v3=%b v4=%b %h/%h expected 0 1 0000/5a5a", r_va[3], r_va[4], r_da[4], r_db[4]);
        end
        checks++;
        if (under_b !== 16'(exp_under) || slip_b !== 16'(exp_slip) || under_b !== 16'd3 || slip_b !== 16'd1) begin
            errors++;
            $display("[TB] FAIL dis_cnt got under=%0d slip=%0d expected %0d %0d", under_b, slip_b, exp_under, exp_slip);
        end
    endtask

    task automatic test_counter_sat_clear();
        logic found;
        do_reset();
        period = 16'd0;
        for (int c = 0; c < MAXC; c++) rp[c] = 1'b1;
        build_model(48, 0);
        run_cycles(48);
        checks++;
        if (under_a !== 4'd15 || under_b !== 16'(exp_under) || exp_under < 20) begin
            errors++;
            $display("[TB] FAIL sat_under got %0d/%0d expected 15/%0d", under_a, under_b, exp_under);
        end
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(posedge mclk);
            #1;
            if (valid_a === 1'b0 && running_a === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL clr_find got no WAIT cycle within 4 cycles expected one");
        end
        cnt_clr = 1'b1;
        @(posedge mclk);
        #2;
        checks++;
        if (under_a !== 4'd1 || under_b !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clr_with_inc got %0d/%0d expected 1/1", under_a, under_b);
        end
        @(posedge mclk);
        #1 cnt_clr = 1'b0;
        #1;
        checks++;
        if (under_a !== 4'd0 || under_b !== 16'd0 || slip_a !== 4'd0 || slip_b !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clr_alone got under=%0d/%0d slip=%0d/%0d expected 0", under_a, under_b, slip_a, slip_b);
        end
    endtask

    task automatic test_slip_saturation();
        do_reset();
        period = 16'd0;
        for (int c = 0; c < MAXC; c++) rp[c] = 1'b0;
        build_model(40, 0);
        run_cycles(40);
        checks++;
        if (slip_a !== 4'd15 || slip_b !== 16'(exp_slip) || under_b !== 16'(exp_under)) begin
            errors++;
            $display("[TB] FAIL slip_sat got slip=%0d/%0d under=%0d expected 15/%0d %0d", slip_a, slip_b, under_b, exp_slip, exp_under);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        period = 16'd1;
        fq = {16'hABCD};
        for (int c = 0; c < MAXC; c++) rp[c] = 1'b0;
        run_cycles(6);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 16'hABCD || slip_a !== 4'd1) begin
            errors++;
            $display("[TB] FAIL ares_pre got v=%b d=%h slip=%0d expected 1 abcd 1", valid_a, data_a, slip_a);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({valid_a, valid_b, running_a, running_b, rinc_a, rinc_b} !== 6'b0 || data_a !== 16'd0 || data_b !== 16'd0 || slip_a !== 4'd0 || slip_b !== 16'd0) begin
            errors++;
            $display("[TB] FAIL ares_now got v=%b%b run=%b%b d=%h/%h slip=%0d/%0d expected all 0", valid_a, valid_b, running_a, running_b, data_a, data_b, slip_a, slip_b);
        end
    endtask

    task automatic test_random();
        int p, len;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            p = int'($urandom_range(0, 4));
            period = 16'(p);
            len = int'($urandom_range(0, 6));
            for (int k = 0; k < len; k++) fq.push_back(16'($urandom));
            for (int c = 0; c < MAXC; c++) rp[c] = ($urandom_range(0, 9) < 7);
            build_model(60, p);
            run_cycles(60);
            for (int c = 0; c < 60; c++) begin
                checks++;
                if ({r_va[c], r_vb[c], r_ra[c], r_rb[c]} !== {e_v[c], e_v[c], e_r[c], e_r[c]}) begin
                    errors++;
                    $display("[TB] FAIL rnd_ctl it %0d p %0d cycle %0d got %b%b%b%b expected %b%b%b%b", it, p, c, r_va[c], r_vb[c], r_ra[c], r_rb[c], e_v[c], e_v[c], e_r[c], e_r[c]);
                end
                if (e_v[c]) begin
                    checks++;
                    if (r_da[c] !== e_d0[c] || r_db[c] !== e_d1[c]) begin
                        errors++;
                        $display("[TB] FAIL rnd_data it %0d cycle %0d got %h/%h expected %h/%h", it, c, r_da[c], r_db[c], e_d0[c], e_d1[c]);
                    end
                end
            end
            checks++;
            if (under_b !== 16'(exp_under) || slip_b !== 16'(exp_slip) || under_a !== 4'(sat4(exp_under)) || slip_a !== 4'(sat4(exp_slip))) begin
                errors++;
                $display("[TB] FAIL rnd_cnt it %0d got %0d %0d %0d %0d expected under=%0d slip=%0d", it, under_a, slip_a, under_b, slip_b, exp_under, exp_slip);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_cadence();
        test_backpressure();
        test_zero_period();
        test_disable_mid_present();
        test_counter_sat_clear();
        test_slip_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_sample_sched.md
# tx_sample_sched

Transmit sample scheduler in the `mclk` domain. It drains the 16-bit TX sample FIFO that the AXI register block fills, and releases exactly one sample per programmable sample period to the downstream serializer over a valid/ready handshake. It substitutes a fill sample on FIFO underrun and keeps saturating underrun and slip counters for software diagnostics.

## Interface
Parameters:
- `DATA_W`, 16, sample width; must match the FIFO width.
- `DIV_W`, 16, width of the sample-period divider.
- `CNT_W`, 16, width of the underrun and slip counters.
- `HOLD_LAST`, 0. 1 = on underrun repeat the last sample; 0 = on underrun send zero.

Ports:
- `mclk`, in, 1, sole clock. All logic is on its rising edge.
- `resetn`, in, 1, asynchronous active-low reset.
- `enable`, in, 1, run control; level-sensitive.
- `period`, in, DIV_W, sample period minus one, in `mclk` cycles.
- `fifo_rempty`, in, 1, FIFO empty flag.
- `fifo_rdata`, in, DATA_W, FIFO head word; show-ahead, valid whenever `fifo_rempty`=0.
- `fifo_rinc`, out, 1, pop strobe; the head is consumed on the edge where this is high.
- `smp_valid`, out, 1, sample valid to the serializer.
- `smp_data`, out, DATA_W, sample data.
- `smp_ready`, in, 1, serializer accepts the sample.
- `underrun_cnt`, out, CNT_W, saturating count of fill samples issued.
- `slip_cnt`, out, CNT_W, saturating count of ticks lost because the serializer stalled.
- `cnt_clr`, in, 1, synchronous clear of both counters.
- `running`, out, 1, high in every state except IDLE.

## Operation
- **Divider.** `div` counts up every cycle while `enable`=1. `tick` = `enable` & (`div` >= `period`). On `tick`, `div` returns to 0.
  - Using >= makes a mid-run decrease of `period` take effect without waiting for wraparound.
  - `period`=0 produces a tick on every cycle.
- **State machine.** States are IDLE, WAIT, PRESENT.
- **IDLE:**
  - `div` is held at 0, `smp_valid`=0, `fifo_rinc`=0.
  - `enable`=1 moves to WAIT on the next edge.
- **WAIT, on `tick`:**
  - If `fifo_rempty`=0: `fifo_rinc`=1 combinationally in that cycle, `smp_data` <= `fifo_rdata`, the last-sample register is updated, and the state moves to PRESENT.
  - If `fifo_rempty`=1: `fifo_rinc`=0. `smp_data` <= the last sample if `HOLD_LAST`=1, otherwise 0. `underrun_cnt` increments and the state moves to PRESENT.
  - `smp_valid` <= 1 in both cases.
- **PRESENT:**
  - `smp_valid` and `smp_data` are held stable until `smp_valid` & `smp_ready`.
  - On that handshake the state returns to WAIT and `smp_valid` goes to 0.
  - A `tick` that occurs in PRESENT without a handshake in the same cycle increments `slip_cnt`. The tick is dropped, not queued. The divider keeps running so the sample cadence is preserved.
- **Disable.** `enable`=0 in any state moves to IDLE on the next edge. It clears `smp_valid` and `div`, and issues no pop. This is the only case where `smp_valid` falls without a handshake.
- **Counters.**
  - Both counters saturate at all-ones.
  - `cnt_clr` alone sets a counter to 0.
  - `cnt_clr` in the same cycle as an increment event sets that counter to 1.
- **Last-sample register.** Reset value is 0. It is not cleared by disable.

## Timing
- **Reset values:** state IDLE; `div`=0; `smp_valid`=0; `smp_data`=0; `fifo_rinc`=0; `underrun_cnt`=0; `slip_cnt`=0; `running`=0; last-sample register 0. Reset takes effect asynchronously at any point, including mid-handshake. No pop is issued in a cycle where `resetn`=0.
- **Enable to first sample.** Let `enable` rise at edge E0.
  - E1: state = WAIT.
  - `div` reaches `period` at edge E1+`period`; that is the tick cycle.
  - `smp_valid`=1 from the following edge.
  - First-sample latency = `period`+2 cycles after `enable` is sampled high.
- **Pop to valid.** `fifo_rinc` is high for exactly one cycle per real sample. It is coincident with the tick cycle; `smp_valid` rises one cycle later.
- **Steady state.** With `smp_ready` tied to 1, consecutive `smp_valid` pulses are `period`+1 cycles apart, each one cycle wide. Handshake to the next tick is always ≥ 1 cycle.
- **Handshake and tick in the same PRESENT cycle.** No slip is counted. The state returns to WAIT and the next sample waits for the following tick.
- **`fifo_rempty` rising in the tick cycle.** The sampled value governs. It is never a pop on empty.
- **`period` = all-ones** is legal; the divider never overflows.

## Test plan
- **Basic cadence.** Reset, `period`=3, preload FIFO with 0x1111, 0x2222, 0x3333, `smp_ready`=1, raise `enable`.
  - Three `smp_valid` pulses, 4 cycles apart; the first is 5 cycles after `enable` is sampled.
  - Data 0x1111, 0x2222, 0x3333.
  - Three single-cycle `fifo_rinc` pulses.
- **Underrun, `HOLD_LAST`=0.** Continue the basic-cadence run with the FIFO now empty, for 2 more periods.
  - Samples 0x0000 and 0x0000.
  - `underrun_cnt`=2, no `fifo_rinc`.
  - Repeat with `HOLD_LAST`=1: samples 0x3333 and 0x3333.
- **Backpressure.** `period`=1, FIFO holds 0xABCD, `smp_ready`=0 for 6 cycles after `smp_valid` rises.
  - `smp_data` stays stable at 0xABCD with `smp_valid` high.
  - `slip_cnt`=3; exactly one pop.
- **Zero period.** `period`=0, FIFO holds 0x0001–0x0008, `smp_ready`=1.
  - A pop on every tick, a sample every 2 cycles (WAIT/PRESENT alternation).
  - Data in order; `underrun_cnt`=0.
- **Disable mid-present.** `enable` falls while `smp_valid`=1.
  - Next edge: `smp_valid`=0, `running`=0, FIFO count unchanged.
  - Re-enable: latency is again `period`+2.
- **Counter saturation and clear.**
  - `CNT_W`=4 with 20 underruns: `underrun_cnt`=15.
  - `cnt_clr` coincident with an underrun: `underrun_cnt`=1.
  - Async reset mid-PRESENT: all outputs at reset values immediately.
